// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit holding the HI/LO registers.
// MULT/MULTU use radix-2 shift-add on operand magnitudes. DIV/DIVU use
// restoring division on operand magnitudes. A FIX cycle applies sign
// correction and writes HI/LO.
// Optional build macro: MDU_FAST_MULT_EN. When defined, multiplies use a
// single-cycle combinational product and skip the iterative CALC phase.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic               op_div;
  logic               neg_result;
  logic               neg_rem;
  logic               div_by_zero;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   operand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     rem;

  logic               in_signed;
  logic               in_div;
  logic               in_neg_a;
  logic               in_neg_b;
  logic [WIDTH-1:0]   in_mag_a;
  logic [WIDTH-1:0]   in_mag_b;

  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH+1:0]   div_shift;
  logic [WIDTH+1:0]   div_trial;
  logic [WIDTH:0]     rem_next;
  logic [WIDTH-1:0]   quo_next;

  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quo_fixed;
  logic [WIDTH-1:0]   rem_fixed;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

`ifdef MDU_FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_prod;

  // Single-cycle magnitude product used in place of the shift-add loop
  always_comb begin
    fast_prod = {{WIDTH{1'b0}}, in_mag_a} * {{WIDTH{1'b0}}, in_mag_b};
  end
`endif

  // Decode the incoming operation and form operand magnitudes (signed ops only)
  always_comb begin
    in_signed = ~op[0];
    in_div    = op[1];
    in_neg_a  = in_signed & a[WIDTH-1];
    in_neg_b  = in_signed & b[WIDTH-1];
    in_mag_a  = in_neg_a ? -a : a;
    in_mag_b  = in_neg_b ? -b : b;
  end

  // One iteration of shift-add multiply and of restoring divide
  always_comb begin
    add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
    mul_next  = acc[0] ? {add_sum, acc[WIDTH-1:1]}
                       : {1'b0, acc[2*WIDTH-1:1]};
    div_shift = {rem, acc[WIDTH-1]};
    div_trial = div_shift - {2'b00, operand};
    rem_next  = div_trial[WIDTH+1] ? div_shift[WIDTH:0] : div_trial[WIDTH:0];
    quo_next  = {acc[WIDTH-2:0], ~div_trial[WIDTH+1]};
  end

  // Sign correction and special cases that produce the final HI/LO values
  always_comb begin
    prod_fixed = neg_result ? -acc : acc;
    quo_fixed  = neg_result ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fixed  = neg_rem ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    fix_hi     = prod_fixed[2*WIDTH-1:WIDTH];
    fix_lo     = prod_fixed[WIDTH-1:0];
    if (op_div) begin
      if (div_by_zero) begin
        fix_hi = a_q;
        fix_lo = '1;
      end else begin
        fix_hi = rem_fixed;
        fix_lo = quo_fixed;
      end
    end
  end

  // Control FSM and datapath registers, including architectural HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      op_div      <= 1'b0;
      neg_result  <= 1'b0;
      neg_rem     <= 1'b0;
      div_by_zero <= 1'b0;
      a_q         <= '0;
      operand     <= '0;
      acc         <= '0;
      rem         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_div      <= in_div;
            neg_result  <= in_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem     <= in_neg_a;
            div_by_zero <= (b == '0);
            a_q         <= a;
            count       <= '0;
            rem         <= '0;
            busy        <= 1'b1;
            if (in_div) begin
              operand <= in_mag_b;
              acc     <= {{WIDTH{1'b0}}, in_mag_a};
              state   <= CALC;
            end else begin
              operand <= in_mag_a;
`ifdef MDU_FAST_MULT_EN
              acc     <= fast_prod;
              state   <= FIX;
`else
              acc     <= {{WIDTH{1'b0}}, in_mag_b};
              state   <= CALC;
`endif
            end
          end else begin
            if (hi_we) begin
              hi <= wd;
            end
            if (lo_we) begin
              lo <= wd;
            end
          end
        end
        CALC: begin
          if (op_div) begin
            acc <= {acc[2*WIDTH-1:WIDTH], quo_next};
            rem <= rem_next;
          end else begin
            acc <= mul_next;
          end
          count <= count + CW'(1);
          if (count == LAST_ITER) begin
            state <= FIX;
          end
        end
        FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed and randomized checks of mul_div_unit against a
// plain-arithmetic reference model. Honours MDU_FAST_MULT_EN for latency.
module tb_mul_div_unit;

  localparam int WIDTH = 32;
`ifdef MDU_FAST_MULT_EN
  localparam bit FAST_MULT = 1'b1;
`else
  localparam bit FAST_MULT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wd;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int checks = 0;
  int errors = 0;

  mul_div_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wd    (wd),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  // Free-running clock, 10 time-unit period
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic void modelOp(input logic [1:0] m_op, input logic [31:0] m_a,
                                  input logic [31:0] m_b, output logic [31:0] m_hi,
                                  output logic [31:0] m_lo);
    int          sa;
    int          sb;
    longint      sprod;
    logic [63:0] pv;
    sa = m_a;
    sb = m_b;
    m_hi = '0;
    m_lo = '0;
    case (m_op)
      2'b00: begin
        sprod = longint'(sa) * longint'(sb);
        pv    = sprod;
        m_hi  = pv[63:32];
        m_lo  = pv[31:0];
      end
      2'b01: begin
        pv   = {32'd0, m_a} * {32'd0, m_b};
        m_hi = pv[63:32];
        m_lo = pv[31:0];
      end
      2'b10: begin
        if (m_b == 32'd0) begin
          m_hi = m_a;
          m_lo = 32'hFFFF_FFFF;
        end else if (m_a == 32'h8000_0000 && m_b == 32'hFFFF_FFFF) begin
          m_hi = 32'd0;
          m_lo = 32'h8000_0000;
        end else begin
          m_lo = 32'(sa / sb);
          m_hi = 32'(sa % sb);
        end
      end
      default: begin
        if (m_b == 32'd0) begin
          m_hi = m_a;
          m_lo = 32'hFFFF_FFFF;
        end else begin
          m_lo = m_a / m_b;
          m_hi = m_a % m_b;
        end
      end
    endcase
  endfunction

  function automatic int expLatency(input logic [1:0] l_op);
    if (!l_op[1] && FAST_MULT) return 1;
    return WIDTH + 1;
  endfunction

  // disturb: 0 none, 1 MTHI while busy, 2 start while busy, 3 lo_we with start
  task automatic applyStimulus(input string tag, input logic [1:0] s_op,
                               input logic [31:0] s_a, input logic [31:0] s_b,
                               input int disturb);
    logic [31:0] e_hi;
    logic [31:0] e_lo;
    logic [31:0] hi_before;
    logic [31:0] lo_before;
    int          edges;
    int          busy_cycles;
    modelOp(s_op, s_a, s_b, e_hi, e_lo);
    hi_before = hi;
    lo_before = lo;
    op    = s_op;
    a     = s_a;
    b     = s_b;
    start = 1'b1;
    if (disturb == 3) begin
      lo_we = 1'b1;
      wd    = 32'h5A5A_0F0F;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    lo_we = 1'b0;
    op    = 2'($urandom_range(0, 3));
    a     = $urandom;
    b     = $urandom;
    if (disturb == 3) begin
      checkOutput({tag, " lo_we dropped"}, 64'(lo), 64'(lo_before));
      checkOutput({tag, " busy after start"}, 64'(busy), 64'd1);
    end
    edges       = 0;
    busy_cycles = 0;
    while (!done && edges < 200) begin
      if (busy) busy_cycles++;
      if (edges == 0 && disturb == 1) begin
        hi_we     = 1'b1;
        wd        = 32'hA5A5_A5A5;
        hi_before = hi;
      end
      if (edges == 0 && disturb == 2) start = 1'b1;
      @(posedge clk);
      #1;
      edges++;
      if (edges == 1 && disturb == 1) begin
        hi_we = 1'b0;
        checkOutput({tag, " mthi ignored while busy"}, 64'(hi), 64'(hi_before));
      end
      if (edges == 1 && disturb == 2) start = 1'b0;
    end
    checkOutput({tag, " latency"}, 64'(edges), 64'(expLatency(s_op)));
    checkOutput({tag, " busy cycles"}, 64'(busy_cycles), 64'(expLatency(s_op)));
    checkOutput({tag, " hi"}, 64'(hi), 64'(e_hi));
    checkOutput({tag, " lo"}, 64'(lo), 64'(e_lo));
  endtask

  // Main stimulus sequence
  initial begin
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [1:0]  r_op;
    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wd    = '0;
    #12;
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset hi", 64'(hi), 64'd0);
    checkOutput("reset lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("multu max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    @(posedge clk);
    #1;
    checkOutput("done single pulse", 64'(done), 64'd0);
    applyStimulus("mult -3*7", 2'b00, 32'hFFFF_FFFD, 32'd7, 0);
    applyStimulus("mult minint sq", 2'b00, 32'h8000_0000, 32'h8000_0000, 0);
    applyStimulus("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    applyStimulus("divu 100/7", 2'b11, 32'd100, 32'd7, 0);
    applyStimulus("divu by zero", 2'b11, 32'h1234_5678, 32'd0, 0);
    applyStimulus("div neg by zero", 2'b10, 32'h8765_4321, 32'd0, 0);
    applyStimulus("div overflow", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);

    @(negedge clk);
    hi_we = 1'b1;
    wd    = 32'hA5A5_A5A5;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    checkOutput("mthi idle", 64'(hi), 64'hA5A5_A5A5);
    @(negedge clk);
    lo_we = 1'b1;
    wd    = 32'h3C3C_C3C3;
    @(posedge clk);
    #1;
    lo_we = 1'b0;
    checkOutput("mtlo idle", 64'(lo), 64'h3C3C_C3C3);
    checkOutput("mtlo keeps hi", 64'(hi), 64'hA5A5_A5A5);

    applyStimulus("divu busy mthi", 2'b11, 32'd1000, 32'd3, 1);
    applyStimulus("div start while busy", 2'b10, 32'hFFFF_FF9C, 32'd7, 2);
    applyStimulus("multu start+lo_we", 2'b01, 32'd3, 32'd5, 3);

    op    = 2'b01;
    a     = 32'hFFFF_FFFF;
    b     = 32'h0001_2345;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midop reset busy", 64'(busy), 64'd0);
    checkOutput("midop reset done", 64'(done), 64'd0);
    checkOutput("midop reset hi", 64'(hi), 64'd0);
    checkOutput("midop reset lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("multu after reset", 2'b01, 32'd3, 32'd5, 0);

    for (int i = 0; i < 40; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = $urandom;
      r_b  = $urandom;
      case ($urandom_range(0, 7))
        0: r_b = 32'd0;
        1: r_b = 32'($urandom_range(1, 15));
        2: r_b = 32'hFFFF_FFFF;
        3: r_a = 32'h8000_0000;
        default: ;
      endcase
      applyStimulus($sformatf("rand%0d op%0d", i, r_op), r_op, r_a, r_b, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
